// File: rtl/ctrl_strobe_pkg.sv
// rtl/ctrl_strobe_pkg.sv - op/state encodings and SEQ order table for ctrl_strobe_gen
package ctrl_strobe_pkg;

    typedef enum logic [1:0] {
        OP_START       = 2'b00,
        OP_CAPTURE     = 2'b01,
        OP_RST_CAPTURE = 2'b10,
        OP_SEQ         = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    localparam int SEQ_LEN = 3;
    localparam op_e SEQ_ORDER [SEQ_LEN] = '{OP_RST_CAPTURE, OP_START, OP_CAPTURE};

    // Strobe vector bit order is {rst_capture, capture, start}.
    function automatic logic [2:0] strobe_mask(input op_e op, input logic [1:0] idx);
        op_e eff;
        if (op == OP_SEQ) begin
            case (idx)
                2'd0:    eff = SEQ_ORDER[0];
                2'd1:    eff = SEQ_ORDER[1];
                default: eff = SEQ_ORDER[2];
            endcase
        end else begin
            eff = op;
        end
        case (eff)
            OP_START:       strobe_mask = 3'b001;
            OP_CAPTURE:     strobe_mask = 3'b010;
            OP_RST_CAPTURE: strobe_mask = 3'b100;
            default:        strobe_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/strobe_timer.sv
// rtl/strobe_timer.sv - loadable down-counter with a one-cycle expire pulse
module strobe_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic         armed_q;

    // Counts load_val..1; disarms after the expire cycle so expire never repeats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else if (load) begin
            count_q <= load_val;
            armed_q <= 1'b1;
        end else if (expire) begin
            armed_q <= 1'b0;
        end else if (armed_q) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expire = armed_q && (count_q == W'(1));

endmodule

// File: rtl/ctrl_strobe_gen.sv
// rtl/ctrl_strobe_gen.sv - command-driven start/capture/rst_capture strobe generator
module ctrl_strobe_gen
    import ctrl_strobe_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    input  logic [1:0] cmd_op_i,
    output logic       cmd_ready_o,
    input  logic       abort_i,
    output logic       start_o,
    output logic       capture_o,
    output logic       rst_capture_o,
    output logic       done_o,
    output logic       aborted_o
);

    localparam int CNT_W = $clog2(((PULSE_W > GAP_W) ? PULSE_W : GAP_W) + 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [1:0]       idx_q, idx_d;
    logic             abort_q, abort_d;
    logic [2:0]       strobe_q, strobe_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expire;

    strobe_timer #(.W(CNT_W)) u_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_START;
            idx_q     <= 2'd0;
            abort_q   <= 1'b0;
            strobe_q  <= 3'b000;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            abort_q   <= abort_d;
            strobe_q  <= strobe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        idx_d     = idx_q;
        abort_d   = abort_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = PULSE_LD;

        case (state_q)
            ST_IDLE: begin
                // abort_i has no meaning here, even alongside a new command
                if (cmd_valid_i) begin
                    op_d     = op_e'(cmd_op_i);
                    idx_d    = 2'd0;
                    abort_d  = 1'b0;
                    state_d  = ST_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (abort_i || tmr_expire) begin
                    abort_d  = abort_q | abort_i;
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            ST_GAP: begin
                // An abort restarts the gap so the full low time is always honoured.
                if (abort_i) begin
                    abort_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end else if (tmr_expire) begin
                    if (!abort_q && op_q == OP_SEQ && idx_q < 2'(SEQ_LEN - 1)) begin
                        idx_d    = idx_q + 2'd1;
                        state_d  = ST_PULSE;
                        tmr_load = 1'b1;
                        tmr_val  = PULSE_LD;
                    end else begin
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        aborted_d = abort_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        strobe_d = (state_d == ST_PULSE) ? strobe_mask(op_d, idx_d) : 3'b000;
        ready_d  = (state_d == ST_IDLE);
    end

    assign cmd_ready_o   = ready_q;
    assign start_o       = strobe_q[0];
    assign capture_o     = strobe_q[1];
    assign rst_capture_o = strobe_q[2];
    assign done_o        = done_q;
    assign aborted_o     = aborted_q;

endmodule

// File: tb/tb_ctrl_strobe_gen.sv
// tb/tb_ctrl_strobe_gen.sv - self-checking bench for ctrl_strobe_gen
module tb_ctrl_strobe_gen;

    localparam int P = 4;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic       abort = 1'b0;
    logic       cmd_ready, start, capture, rst_capture, done, aborted;
    logic [5:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ctrl_strobe_gen #(.PULSE_W(P), .GAP_W(G)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_op_i      (cmd_op),
        .cmd_ready_o   (cmd_ready),
        .abort_i       (abort),
        .start_o       (start),
        .capture_o     (capture),
        .rst_capture_o (rst_capture),
        .done_o        (done),
        .aborted_o     (aborted)
    );

    // {ready, done, aborted, rst_capture, capture, start}
    assign obs = {cmd_ready, done, aborted, rst_capture, capture, start};

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected outputs t cycles after the accepting edge; ab = cycle in which abort_i is driven (-1 none).
    function automatic logic [5:0] model(input logic [1:0] op, input int t, input int ab);
        int n, d, j, r;
        logic [2:0] m;
        n = (op == 2'd3) ? 3 : 1;
        d = n * (P + G);
        if (ab >= 0 && ab < d && t > ab) begin
            if (t <= ab + G) return 6'b000000;
            if (t == ab + G + 1) return 6'b111000;
            return 6'b100000;
        end
        if (t >= d) return (t == d) ? 6'b110000 : 6'b100000;
        j = t / (P + G);
        r = t % (P + G);
        if (r >= P) return 6'b000000;
        case (op)
            2'd0:    m = 3'b001;
            2'd1:    m = 3'b010;
            2'd2:    m = 3'b100;
            default: m = (j == 0) ? 3'b100 : (j == 1) ? 3'b001 : 3'b010;
        endcase
        return {3'b000, m};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_values: got %b want %b", obs, 6'b100000);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (obs !== 6'b100000) begin
                n_fail++;
                $display("FAIL reset_quiet c=%0d: got %b want %b", i, obs, 6'b100000);
            end
        end
    endtask

    task automatic test_start;
        logic [5:0] exp;
        cmd_valid = 1'b1;
        cmd_op = 2'd0;
        step();
        cmd_valid = 1'b0;
        for (int t = 0; t <= P + G + 1; t++) begin
            exp = (t < P) ? 6'b000001 : (t < P + G) ? 6'b000000 :
                  (t == P + G) ? 6'b110000 : 6'b100000;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL start_single t=%0d: got %b want %b", t, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_seq;
        logic [5:0] exp;
        logic [2:0] prev = 3'b000;
        int rises [3] = '{0, 0, 0};
        cmd_valid = 1'b1;
        cmd_op = 2'd3;
        step();
        cmd_valid = 1'b0;
        for (int t = 0; t <= 3 * (P + G); t++) begin
            exp = {t == 18, t == 18, 1'b0, t < 4, (t >= 12 && t < 16), (t >= 6 && t < 10)};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL seq_timeline t=%0d: got %b want %b", t, obs, exp);
            end
            for (int b = 0; b < 3; b++)
                if (obs[b] && !prev[b]) rises[b]++;
            prev = obs[2:0];
            step();
        end
        for (int b = 0; b < 3; b++) begin
            n_tests++;
            if (rises[b] !== 1) begin
                n_fail++;
                $display("FAIL seq_edges strobe=%0d: got %0d want 1", b, rises[b]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cap_fall = -1, cap_len = 0, start_rise = -1, start_len = 0, done_t = -1, n_done = 0;
        logic prev_start = 1'b0, prev_cap = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        step();
        cmd_op = 2'd0;
        for (int t = 0; t < 16; t++) begin
            if (capture) cap_len++;
            if (start) start_len++;
            if (prev_cap && !capture && cap_fall < 0) cap_fall = t;
            if (start && !prev_start && start_rise < 0) start_rise = t;
            if (done) begin
                n_done++;
                if (done_t < 0) done_t = t;
            end
            if (start) cmd_valid = 1'b0;
            prev_cap = capture;
            prev_start = start;
            step();
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (done_t !== P + G) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d want %0d", done_t, P + G);
        end
        n_tests++;
        if (start_rise !== P + G + 1) begin
            n_fail++;
            $display("FAIL b2b_accept_in_done: got %0d want %0d", start_rise, P + G + 1);
        end
        n_tests++;
        if (start_rise - cap_fall < G || cap_fall < 0) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d want >=%0d", start_rise - cap_fall, G);
        end
        n_tests++;
        if (cap_len !== P || start_len !== P || n_done !== 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: got cap=%0d start=%0d done=%0d want %0d %0d 2",
                     cap_len, start_len, n_done, P, P);
        end
    endtask

    task automatic test_abort;
        logic [5:0] exp;
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        step();
        cmd_valid = 1'b0;
        for (int t = 0; t <= G + 3; t++) begin
            exp = (t < 2) ? 6'b000010 : (t < 2 + G) ? 6'b000000 :
                  (t == 2 + G) ? 6'b111000 : 6'b100000;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL abort_capture t=%0d: got %b want %b", t, obs, exp);
            end
            abort = (t == 1);
            step();
        end
        abort = 1'b0;
        cmd_valid = 1'b1;
        abort = 1'b1;
        cmd_op = 2'd0;
        step();
        cmd_valid = 1'b0;
        abort = 1'b0;
        for (int t = 0; t <= P + G; t++) begin
            exp = model(2'd0, t, -1);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL abort_idle_accept t=%0d: got %b want %b", t, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_reset_mid;
        logic [5:0] exp;
        cmd_valid = 1'b1;
        cmd_op = 2'd3;
        step();
        cmd_valid = 1'b0;
        repeat (7) step();
        n_tests++;
        if (obs !== 6'b000001) begin
            n_fail++;
            $display("FAIL mid_seq_start: got %b want %b", obs, 6'b000001);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== 6'b100000) begin
            n_fail++;
            $display("FAIL async_reset_drop: got %b want %b", obs, 6'b100000);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (obs !== 6'b100000) begin
                n_fail++;
                $display("FAIL reset_lost_cmd c=%0d: got %b want %b", i, obs, 6'b100000);
            end
        end
        cmd_valid = 1'b1;
        cmd_op = 2'd2;
        step();
        cmd_valid = 1'b0;
        for (int t = 0; t <= P + G + 1; t++) begin
            exp = model(2'd2, t, -1);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL post_reset_rstcap t=%0d: got %b want %b", t, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_random;
        logic [1:0] op;
        int ab, len, d, idle_gap;
        for (int c = 0; c < 40; c++) begin
            op = 2'($urandom_range(0, 3));
            d = (op == 2'd3) ? 3 * (P + G) : (P + G);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, d - 1)) : -1;
            len = (ab >= 0) ? ab + G + 1 : d;
            idle_gap = $urandom_range(0, 2);
            cmd_valid = 1'b1;
            cmd_op = op;
            abort = 1'($urandom_range(0, 1));
            step();
            for (int t = 0; t <= len; t++) begin
                n_tests++;
                if (obs !== model(op, t, ab)) begin
                    n_fail++;
                    $display("FAIL random c=%0d op=%0d ab=%0d t=%0d: got %b want %b",
                             c, op, ab, t, obs, model(op, t, ab));
                end
                abort = (t == ab);
                cmd_valid = (t < len) ? 1'($urandom_range(0, 1)) : 1'b0;
                cmd_op = (t < len) ? 2'($urandom_range(0, 3)) : op;
                if (t < len) step();
            end
            abort = 1'b0;
            cmd_valid = 1'b0;
            for (int i = 0; i < idle_gap; i++) begin
                step();
                n_tests++;
                if (obs !== 6'b100000) begin
                    n_fail++;
                    $display("FAIL random_idle c=%0d: got %b want %b", c, obs, 6'b100000);
                end
                abort = 1'($urandom_range(0, 1));
            end
            abort = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_seq();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
